register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   General-purpose register file: 32 x 32-bit storage, one synchronous write port and two
//   independent asynchronous read ports (A, B). Sits in the CPU datapath between decode
//   (which supplies the read addresses) and writeback (which supplies WAdd/DIn/EnW).
// PARAMETERS
//   DATA_W   32  width of each register and of DIn/DA/DB
//   ADDR_W    5  address width; depth = 2**ADDR_W (32 entries)
// PORTS
//   Clk    in   1       single clock; all state updates on rising edge
//   Reset  in   1       asynchronous, active-low reset (asserted when 0)
//   EnW    in   1       write enable
//   WAdd   in   ADDR_W  write address
//   DIn    in   DATA_W  write data
//   ReadA  in   ADDR_W  read address, port A
//   ReadB  in   ADDR_W  read address, port B
//   DA     out  DATA_W  read data, port A
//   DB     out  DATA_W  read data, port B
//   Port order as listed (positional instantiation is used).
// BEHAVIOUR
//   - Reset low: every entry cleared to 0 immediately, regardless of Clk; DA = DB = 0.
//     Reset has priority over a write in the same cycle. Release is synchronised by the
//     caller; the first write takes effect on the first rising edge with Reset high.
//   - Write: on rising Clk edge with Reset=1 and EnW=1, entry[WAdd] <= DIn. EnW=0: no change.
//   - Read: combinational; DA = entry[ReadA], DB = entry[ReadB]. No registered output,
//     zero-cycle latency from address change.
//   - Same address on A and B: both return the same value.
//   - Read and write to the same address in the same cycle: read returns the OLD value until
//     the edge, then the new value (no write-through bypass).
//   - Addresses are full-range (0..31); no out-of-range case exists. No wrap logic needed.
//   - DIn is stored bit-exact; no arithmetic, no sign handling.
// CONFIGURATION
//   REGFILE_ZERO_REG_EN defined: entry 0 is hard-wired to 0. Writes to WAdd=0 are ignored,
//     and DA/DB read 0 when the address is 0.
//   REGFILE_ZERO_REG_EN undefined (default): entry 0 is an ordinary writable register.
// STRUCTURE
//   - Package regfile_pkg: DATA_W/ADDR_W defaults, DEPTH = 2**ADDR_W, and a reg_addr_t /
//     reg_data_t typedef pair.
//   - Sub-module regfile_entry: one DATA_W-bit register with async active-low clear and a
//     write enable. register_file instantiates DEPTH of them via generate, decodes
//     WAdd & EnW into one-hot enables, and drives two DEPTH:1 read muxes.
// TESTING
//   1. Reset=0 while DIn=5, EnW=1 -> all entries 0, DA=DB=0 for every ReadA/ReadB.
//   2. Reset=1, EnW=1, WAdd=0, DIn=5, edge -> ReadA=0 gives DA=5; with ZERO_REG_EN, DA=0.
//   3. Sweep WAdd 1..31 with DIn=5*k, EnW=1 -> ReadA/ReadB sweep returns 5*k at each k on
//      both ports independently; ReadA!=ReadB gives distinct correct values.
//   4. EnW=0, WAdd=3, DIn=0xDEADBEEF, edge -> entry 3 keeps 15.
//   5. ReadA=WAdd=7, DIn=0x1234, EnW=1 -> DA holds the old value before the edge and
//      0x1234 after the edge.
//   6. Assert Reset mid-cycle (between edges) after the entries are loaded -> DA/DB go to 0
//      at once, without waiting for Clk.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared sizing constants and typedefs for the general-purpose register file.
//   DATA_W : width of one register and of the write/read data buses
//   ADDR_W : address width; DEPTH = 2**ADDR_W entries
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_entry.sv
// -----------------------------------------------------------------------------
// regfile_entry
//   One storage word of the register file: a W-bit register with asynchronous
//   active-low clear and a synchronous write enable.
// Ports
//   clk   in  1   rising-edge clock
//   rst_n in  1   asynchronous clear, active low
//   i_en  in  1   load i_d on the next rising edge
//   i_d   in  W   write data
//   o_q   out W   stored value
// -----------------------------------------------------------------------------
module regfile_entry
  import regfile_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // NOTE: the whole array is cleared by reset on purpose (the datapath relies
  // on every register reading 0 after reset), so each word is a real flop
  // with an async clear rather than an unreset RAM cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : regfile_entry

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   General-purpose register file: DEPTH x DATA_W storage, one synchronous
//   write port and two independent combinational read ports (A, B).
//   Reads have no write-through bypass: a read of the address being written
//   returns the old value until the clock edge.
// Ports
//   Clk    in   1       rising-edge clock
//   Reset  in   1       asynchronous clear, active low
//   EnW    in   1       write enable
//   WAdd   in   ADDR_W  write address
//   DIn    in   DATA_W  write data
//   ReadA  in   ADDR_W  read address, port A
//   ReadB  in   ADDR_W  read address, port B
//   DA     out  DATA_W  read data, port A
//   DB     out  DATA_W  read data, port B
// Configuration
//   REGFILE_ZERO_REG_EN : when defined, entry 0 is hard-wired to zero (writes
//                         to address 0 are dropped, reads of 0 return 0).
//                         Undefined by default: entry 0 is an ordinary register.
// -----------------------------------------------------------------------------
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              EnW,
  input  logic [ADDR_W-1:0] WAdd,
  input  logic [DATA_W-1:0] DIn,
  input  logic [ADDR_W-1:0] ReadA,
  input  logic [ADDR_W-1:0] ReadB,
  output logic [DATA_W-1:0] DA,
  output logic [DATA_W-1:0] DB
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] w_q [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (ZERO_REG && (i == 0)) begin : g_zero
      // No storage at all for the hard-wired zero register.
      assign w_q[i] = '0;
    end else begin : g_reg
      // One-hot write decode: only the addressed entry sees an enable.
      logic w_wen;
      assign w_wen = EnW && (WAdd == ADDR_W'(i));

      regfile_entry #(
        .W (DATA_W)
      ) u_entry (
        .clk   (Clk),
        .rst_n (Reset),
        .i_en  (w_wen),
        .i_d   (DIn),
        .o_q   (w_q[i])
      );
    end
  end

  // Two independent DEPTH:1 read muxes, purely combinational.
  assign DA = w_q[ReadA];
  assign DB = w_q[ReadB];

endmodule : register_file

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Self-checking bench for register_file. A plain array model tracks what
//   each register must hold; a compare process checks both read ports against
//   it on every falling clock edge, and directed steps pin hand-computed values.
// -----------------------------------------------------------------------------
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic          Clk;
  logic          Reset;
  logic          EnW;
  logic [AW-1:0] WAdd;
  logic [DW-1:0] DIn;
  logic [AW-1:0] ReadA;
  logic [AW-1:0] ReadB;
  logic [DW-1:0] DA;
  logic [DW-1:0] DB;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  logic [DW-1:0] model [N];

  register_file dut (
    .Clk   (Clk),
    .Reset (Reset),
    .EnW   (EnW),
    .WAdd  (WAdd),
    .DIn   (DIn),
    .ReadA (ReadA),
    .ReadB (ReadB),
    .DA    (DA),
    .DB    (DB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what each register must contain, straight from the behaviour rules.
  function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a);
    if (ZERO && a == '0) return '0;
    return model[a];
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < N; i++) model[i] = '0;
    end else if (EnW && !(ZERO && WAdd == '0)) begin
      model[WAdd] = DIn;
    end
  end

  // Every cycle: both read ports must match the model.
  always @(negedge Clk) begin
    if (cmp_en) begin
      check("cyc_DA", DA, expect_rd(ReadA));
      check("cyc_DB", DB, expect_rd(ReadB));
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) model[i] = '0;
    // 1. Reset held low while a write is requested.
    Reset = 1'b0;
    EnW   = 1'b1;
    WAdd  = '0;
    DIn   = 32'd5;
    ReadA = '0;
    ReadB = 5'd31;
    tick();
    cmp_en = 1'b1;
    tick();
    for (int k = 0; k < N; k += 5) begin
      ReadA = AW'(k);
      ReadB = AW'(N - 1 - k);
      #1;
      check("rst_DA", DA, 32'd0);
      check("rst_DB", DB, 32'd0);
    end

    // 2. Release reset, write 5 into entry 0.
    Reset = 1'b1;
    EnW   = 1'b1;
    WAdd  = '0;
    DIn   = 32'd5;
    tick();
    EnW   = 1'b0;
    ReadA = '0;
    #1;
    check("wr0_DA", DA, ZERO ? 32'd0 : 32'd5);

    // 3. Fill entries 1..31 with 5*k, then sweep both ports.
    EnW = 1'b1;
    for (int k = 1; k < N; k++) begin
      WAdd = AW'(k);
      DIn  = DW'(5 * k);
      tick();
    end
    EnW = 1'b0;
    for (int k = 1; k < N; k++) begin
      ReadA = AW'(k);
      ReadB = AW'(N - k);
      #1;
      check("sweep_DA", DA, DW'(5 * k));
      check("sweep_DB", DB, DW'(5 * (N - k)));
    end
    ReadA = 5'd3;
    ReadB = 5'd31;
    #1;
    check("lit_r3", DA, 32'd15);
    check("lit_r31", DB, 32'd155);
    tick();

    // 4. Write with EnW low must not change entry 3.
    EnW  = 1'b0;
    WAdd = 5'd3;
    DIn  = 32'hDEAD_BEEF;
    tick();
    ReadA = 5'd3;
    #1;
    check("noen_r3", DA, 32'd15);

    // 5. Read and write the same address: old value before edge, new after.
    ReadA = 5'd7;
    WAdd  = 5'd7;
    DIn   = 32'h0000_1234;
    EnW   = 1'b1;
    #1;
    check("rw7_old", DA, 32'd35);
    tick();
    EnW = 1'b0;
    check("rw7_new", DA, 32'h0000_1234);

    // Same address on both ports.
    ReadA = 5'd9;
    ReadB = 5'd9;
    #1;
    check("same_DA", DA, 32'd45);
    check("same_DB", DB, 32'd45);
    tick();

    // 6. Asynchronous reset between edges clears outputs at once.
    ReadA = 5'd7;
    ReadB = 5'd20;
    #1;
    check("pre_rst_DA", DA, 32'h0000_1234);
    check("pre_rst_DB", DB, 32'd100);
    Reset = 1'b0;
    #1;
    check("async_DA", DA, 32'd0);
    check("async_DB", DB, 32'd0);
    tick();
    Reset = 1'b1;
    tick();

    // Post-reset write still works and the rest stay cleared.
    EnW  = 1'b1;
    WAdd = 5'd12;
    DIn  = 32'hA5A5_5A5A;
    tick();
    EnW   = 1'b0;
    ReadA = 5'd12;
    ReadB = 5'd13;
    #1;
    check("post_DA", DA, 32'hA5A5_5A5A);
    check("post_DB", DB, 32'd0);
    tick();
    tick();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_register_file
